gtfwizard_0_example_prbs_rx_checker: RTL and testbench

// - PRBS31 checker on GTF RAW-mode RX user data; produces rx_data_good that drives gtfwizard_0_example_init.rx_data_good_in.
// - Self-synchronising: seeds from received bits, then flags word errors and keeps a saturating error count.
// - Sits between GT RX datapath and init logic; all logic in RX usrclk2 domain (init resynchronises rx_data_good).

---
 rtl/gtfwizard_0_example_prbs_rx_checker.sv | 186 ++++++++++++++++++
 tb/tb_gtfwizard_0_example_prbs_rx_checker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gtfwizard_0_example_prbs_rx_checker.sv
// PRBS31 checker for GTF RAW-mode RX user data (rx_usrclk2 domain).
// Seeds its 31-bit history from received bits, then checks each valid word
// against b[n] = b[n-31] ^ b[n-28], raising rx_data_good_out after
// P_GOOD_WINDOW consecutive clean words and re-seeding after P_LOSS_THRESH
// consecutive errored words.
// Optional feature: define GTFWIZ_PRBS_BIT_ERR_CNT_EN to enable the
// pipelined errored-bit counter; otherwise prbs_bit_err_ctr_out is 0.
//
// state    | meaning
// ST_SEED  | filling history from received bits, errors not detectable
// ST_CHECK | comparing each valid word against the predicted PRBS31 bits
module gtfwizard_0_example_prbs_rx_checker #(
  parameter int P_DATA_WIDTH  = 32,
  parameter int P_GOOD_WINDOW = 8,
  parameter int P_LOSS_THRESH = 4,
  parameter int P_CNT_WIDTH   = 16
) (
  input  logic                    rx_usrclk2_in,
  input  logic                    reset_in,
  input  logic                    rx_data_valid_in,
  input  logic [P_DATA_WIDTH-1:0] rx_data_in,
  input  logic                    prbs_err_clr_in,
  output logic                    rx_data_good_out,
  output logic                    prbs_locked_out,
  output logic [P_CNT_WIDTH-1:0]  prbs_err_word_ctr_out,
  output logic [31:0]             prbs_bit_err_ctr_out
);

  localparam int SEED_WORDS = (31 + P_DATA_WIDTH - 1) / P_DATA_WIDTH;
  localparam int SEED_W     = $clog2(SEED_WORDS + 1);
  localparam int CLEAN_W    = $clog2(P_GOOD_WINDOW + 1);
  localparam int LOSS_W     = $clog2(P_LOSS_THRESH + 1);

  localparam logic [SEED_W-1:0]  SEED_LAST = SEED_W'(SEED_WORDS - 1);
  localparam logic [CLEAN_W-1:0] GOOD_FULL = CLEAN_W'(P_GOOD_WINDOW);
  localparam logic [CLEAN_W-1:0] GOOD_M1   = CLEAN_W'(P_GOOD_WINDOW - 1);
  localparam logic [LOSS_W-1:0]  LOSS_M1   = LOSS_W'(P_LOSS_THRESH - 1);

  typedef enum logic {ST_SEED, ST_CHECK} state_t;

  state_t                   state_q, state_d;
  logic [30:0]              hist_q, hist_d;
  logic [SEED_W-1:0]        seed_q, seed_d;
  logic [CLEAN_W-1:0]       clean_q, clean_d;
  logic [LOSS_W-1:0]        loss_q, loss_d;
  logic                     good_q, good_d;
  logic                     locked_q, locked_d;
  logic [P_CNT_WIDTH-1:0]   werr_q, werr_d;

  logic [P_DATA_WIDTH+30:0] x_vec;
  logic [P_DATA_WIDTH-1:0]  exp_vec;
  logic [P_DATA_WIDTH-1:0]  err_vec;
  logic                     word_err;
  logic                     err_hit;

  // Prediction: history (oldest at bit 0) followed by the current word
  always_comb begin
    x_vec   = {rx_data_in, hist_q};
    exp_vec = '0;
    for (int k = 0; k < P_DATA_WIDTH; k++) begin
      exp_vec[k] = x_vec[k] ^ x_vec[k+3];
    end
    err_vec  = rx_data_in ^ exp_vec;
    word_err = |err_vec;
  end

  // Next-state, counters and registered outputs
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    seed_d   = seed_q;
    clean_d  = clean_q;
    loss_d   = loss_q;
    good_d   = good_q;
    werr_d   = werr_q;
    err_hit  = 1'b0;
    if (rx_data_valid_in) begin
      hist_d = x_vec[P_DATA_WIDTH+30:P_DATA_WIDTH];
      case (state_q)
        ST_SEED: begin
          clean_d = '0;
          loss_d  = '0;
          good_d  = 1'b0;
          if (seed_q == SEED_LAST) begin
            state_d = ST_CHECK;
            seed_d  = '0;
          end else begin
            seed_d = seed_q + 1'b1;
          end
        end
        default: begin
          if (word_err) begin
            err_hit = 1'b1;
            clean_d = '0;
            good_d  = 1'b0;
            if (loss_q == LOSS_M1) begin
              state_d = ST_SEED;
              seed_d  = '0;
              loss_d  = '0;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end else begin
            loss_d = '0;
            if (clean_q != GOOD_FULL) clean_d = clean_q + 1'b1;
            good_d = (clean_q >= GOOD_M1);
          end
        end
      endcase
    end
    locked_d = (state_d == ST_CHECK);
    if (prbs_err_clr_in) begin
      werr_d = '0;
    end else if (err_hit && !(&werr_q)) begin
      werr_d = werr_q + 1'b1;
    end
  end

`ifdef GTFWIZ_PRBS_BIT_ERR_CNT_EN
  logic [6:0]  pop_q, pop_d;
  logic        pend_q, pend_d;
  logic [31:0] berr_q, berr_d;
  logic [32:0] berr_sum;

  // Popcount stage, then a clamped add one cycle later
  always_comb begin
    pop_d = '0;
    for (int k = 0; k < P_DATA_WIDTH; k++) begin
      pop_d = pop_d + 7'(err_vec[k]);
    end
    pend_d   = err_hit && !prbs_err_clr_in;
    berr_sum = {1'b0, berr_q} + 33'(pop_q);
    berr_d   = berr_q;
    if (prbs_err_clr_in) begin
      berr_d = '0;
    end else if (pend_q) begin
      berr_d = berr_sum[32] ? 32'hFFFF_FFFF : berr_sum[31:0];
    end
  end

  // Bit-counter pipeline registers
  always_ff @(posedge rx_usrclk2_in or posedge reset_in) begin
    if (reset_in) begin
      pop_q  <= '0;
      pend_q <= 1'b0;
      berr_q <= '0;
    end else begin
      pop_q  <= pop_d;
      pend_q <= pend_d;
      berr_q <= berr_d;
    end
  end

  assign prbs_bit_err_ctr_out = berr_q;
`else
  assign prbs_bit_err_ctr_out = 32'd0;
`endif

  // Checker FSM state, history, counters and output registers
  always_ff @(posedge rx_usrclk2_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= ST_SEED;
      hist_q   <= '0;
      seed_q   <= '0;
      clean_q  <= '0;
      loss_q   <= '0;
      good_q   <= 1'b0;
      locked_q <= 1'b0;
      werr_q   <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      seed_q   <= seed_d;
      clean_q  <= clean_d;
      loss_q   <= loss_d;
      good_q   <= good_d;
      locked_q <= locked_d;
      werr_q   <= werr_d;
    end
  end

  assign rx_data_good_out      = good_q;
  assign prbs_locked_out       = locked_q;
  assign prbs_err_word_ctr_out = werr_q;

endmodule

// File: tb/tb_gtfwizard_0_example_prbs_rx_checker.sv
// Directed bench for the PRBS31 RX checker.
// Instance A: default parameters. Instance B: 16-bit words (two seed words).
// Instance C: 4-bit word counter with loss threshold 15, so counter saturation
// can be reached in a few dozen words.
// Flipping bit 0 of a word keeps all three resulting error taps (bits 0, 28, 31)
// inside that word; flipping bit 5 spills two taps (bits 1 and 4) into the next
// word, so that word is flagged too.
module tb_gtfwizard_0_example_prbs_rx_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_valid = 1'b0, a_clr = 1'b0, a_good, a_locked;
  logic [31:0] a_data = '0, a_berr;
  logic [15:0] a_werr;

  logic        b_valid = 1'b0, b_clr = 1'b0, b_good, b_locked;
  logic [15:0] b_data = '0, b_werr;
  logic [31:0] b_berr;

  logic        c_valid = 1'b0, c_clr = 1'b0, c_good, c_locked;
  logic [31:0] c_data = '0, c_berr;
  logic [3:0]  c_werr;

  logic [30:0] ga = 31'h1234_5678;
  logic [30:0] gb = 31'h0ACE_1357;
  logic [30:0] gc = 31'h7FED_CBA9;

  int n_pass  = 0;
  int n_total = 0;

`ifdef GTFWIZ_PRBS_BIT_ERR_CNT_EN
  localparam logic [31:0] BERR_AFTER_FLIP0 = 32'd3;
  localparam logic [31:0] BERR_AFTER_FLIP5 = 32'd6;
`else
  localparam logic [31:0] BERR_AFTER_FLIP0 = 32'd0;
  localparam logic [31:0] BERR_AFTER_FLIP5 = 32'd0;
`endif

  always #5 clk = ~clk;

  gtfwizard_0_example_prbs_rx_checker u_a (
    .rx_usrclk2_in(clk), .reset_in(rst), .rx_data_valid_in(a_valid),
    .rx_data_in(a_data), .prbs_err_clr_in(a_clr), .rx_data_good_out(a_good),
    .prbs_locked_out(a_locked), .prbs_err_word_ctr_out(a_werr),
    .prbs_bit_err_ctr_out(a_berr));

  gtfwizard_0_example_prbs_rx_checker #(.P_DATA_WIDTH(16)) u_b (
    .rx_usrclk2_in(clk), .reset_in(rst), .rx_data_valid_in(b_valid),
    .rx_data_in(b_data), .prbs_err_clr_in(b_clr), .rx_data_good_out(b_good),
    .prbs_locked_out(b_locked), .prbs_err_word_ctr_out(b_werr),
    .prbs_bit_err_ctr_out(b_berr));

  gtfwizard_0_example_prbs_rx_checker #(.P_CNT_WIDTH(4), .P_LOSS_THRESH(15)) u_c (
    .rx_usrclk2_in(clk), .reset_in(rst), .rx_data_valid_in(c_valid),
    .rx_data_in(c_data), .prbs_err_clr_in(c_clr), .rx_data_good_out(c_good),
    .prbs_locked_out(c_locked), .prbs_err_word_ctr_out(c_werr),
    .prbs_bit_err_ctr_out(c_berr));

  // Source-side PRBS31 generator: s[i] holds b[n-31+i]
  task automatic prbs_word(inout logic [30:0] s, input int w, output logic [63:0] word);
    logic nb;
    word = '0;
    for (int i = 0; i < w; i++) begin
      nb       = s[0] ^ s[3];
      s        = {nb, s[30:1]};
      word[i]  = nb;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic a_word(input logic v, input logic [31:0] d);
    a_valid = v; a_data = d;
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic a_clean();
    logic [63:0] w;
    prbs_word(ga, 32, w);
    a_word(1'b1, w[31:0]);
  endtask

  task automatic a_flip(input logic [31:0] mask);
    logic [63:0] w;
    prbs_word(ga, 32, w);
    a_word(1'b1, w[31:0] ^ mask);
  endtask

  task automatic b_clean();
    logic [63:0] w;
    prbs_word(gb, 16, w);
    b_valid = 1'b1; b_data = w[15:0];
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic c_step(input logic [31:0] mask);
    logic [63:0] w;
    prbs_word(gc, 32, w);
    c_valid = 1'b1; c_data = w[31:0] ^ mask;
    @(posedge clk); #1;
    c_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_good", a_good, 0);
    chk("rst_locked", a_locked, 0);
    chk("rst_werr", a_werr, 0);
    chk("rst_berr", a_berr, 0);
    chk("rst_b_locked", b_locked, 0);
    rst = 1'b0;

    // Clean stream: lock after one word, good after word 9
    a_clean();
    chk("clean_lock1", a_locked, 1);
    chk("clean_good1", a_good, 0);
    repeat (7) a_clean();
    chk("clean_good8", a_good, 0);
    a_clean();
    chk("clean_good9", a_good, 1);
    repeat (3) a_clean();
    chk("clean_good12", a_good, 1);
    chk("clean_werr12", a_werr, 0);

    // Single line-bit flip contained in one word
    a_flip(32'h0000_0001);
    chk("flip0_werr", a_werr, 1);
    chk("flip0_good", a_good, 0);
    chk("flip0_berr_lag", a_berr, 0);
    a_clean();
    chk("flip0_berr", a_berr, BERR_AFTER_FLIP0);
    chk("flip0_good_after", a_good, 0);
    repeat (6) a_clean();
    chk("flip0_good7", a_good, 0);
    a_clean();
    chk("flip0_good8", a_good, 1);

    // Bit 5 flip: the next word carries the two later error taps
    a_flip(32'h0000_0020);
    chk("flip5_werr_a", a_werr, 2);
    chk("flip5_good", a_good, 0);
    a_clean();
    chk("flip5_werr_b", a_werr, 3);
    chk("flip5_locked", a_locked, 1);
    a_clean();
    chk("flip5_berr", a_berr, BERR_AFTER_FLIP5);
    repeat (6) a_clean();
    chk("flip5_good7", a_good, 0);
    a_clean();
    chk("flip5_good8", a_good, 1);

    // Loss of lock on four garbage words, then relock on one clean word
    repeat (3) a_word(1'b1, 32'hFFFF_0000);
    chk("loss_werr3", a_werr, 6);
    chk("loss_locked3", a_locked, 1);
    a_word(1'b1, 32'hFFFF_0000);
    chk("loss_werr4", a_werr, 7);
    chk("loss_locked4", a_locked, 0);
    chk("loss_good4", a_good, 0);
    a_clean();
    chk("relock", a_locked, 1);
    repeat (2) a_clean();
    chk("relock_werr", a_werr, 7);
    chk("relock_good", a_good, 0);

    // 16-bit instance needs two seed words
    b_clean();
    chk("b_seed1", b_locked, 0);
    b_clean();
    chk("b_seed2", b_locked, 1);
    repeat (7) b_clean();
    chk("b_good9", b_good, 0);
    b_clean();
    chk("b_good10", b_good, 1);
    chk("b_werr", b_werr, 0);

    // Asynchronous reset between clock edges
    #3 rst = 1'b1;
    #1;
    chk("arst_a_good", a_good, 0);
    chk("arst_a_locked", a_locked, 0);
    chk("arst_a_werr", a_werr, 0);
    chk("arst_b_good", b_good, 0);
    chk("arst_b_locked", b_locked, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    b_clean();
    chk("b_reseed1", b_locked, 0);
    b_clean();
    chk("b_reseed2", b_locked, 1);

    // Valid toggling every cycle with garbage on invalid cycles
    for (int i = 1; i <= 9; i++) begin
      a_clean();
      if (i == 1) chk("tog_lock", a_locked, 1);
      if (i == 8) chk("tog_good8", a_good, 0);
      if (i == 9) chk("tog_good9", a_good, 1);
      a_word(1'b0, 32'hDEAD_BEEF);
    end
    chk("tog_good_hold", a_good, 1);
    chk("tog_werr", a_werr, 0);

    // Word counter saturation and clear priority (4-bit counter)
    c_step(32'h0);
    chk("c_lock", c_locked, 1);
    repeat (14) c_step(32'h1);
    chk("c_werr_e", c_werr, 4'hE);
    chk("c_locked_e", c_locked, 1);
    c_step(32'h0);
    for (int i = 0; i < 3; i++) begin
      c_step(32'h1);
      chk("c_werr_sat", c_werr, 4'hF);
    end
    c_clr = 1'b1;
    c_step(32'h1);
    c_clr = 1'b0;
    chk("c_clr", c_werr, 0);
    c_step(32'h1);
    chk("c_after_clr", c_werr, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
